// File: rtl/loop_player.sv
// Playback engine: walks a [start,end) window of the sample RAM one sample per tick, applies gain with saturation.
// Optional echo tap enabled by defining LOOP_PLAYER_ECHO_EN.
module loop_player #(
    parameter int ADDR_W      = 16,
    parameter int SAMPLE_W    = 8,
    parameter int RAM_LATENCY = 2,
    parameter int ECHO_DELAY  = 3000
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                play_in,
    input  logic                loop_in,
    input  logic [ADDR_W-1:0]   start_addr_in,
    input  logic [ADDR_W-1:0]   end_addr_in,
    input  logic                sample_tick_in,
    input  logic [3:0]          volume_in,
    output logic [ADDR_W-1:0]   ram_addr_out,
    input  logic [SAMPLE_W-1:0] ram_data_in,
    output logic [SAMPLE_W-1:0] sample_out,
    output logic                sample_valid_out,
    output logic                busy_out,
    output logic                done_out
);

`ifdef LOOP_PLAYER_ECHO_EN
    localparam int CAP_CNT = RAM_LATENCY + 1;
`else
    localparam int CAP_CNT = RAM_LATENCY;
`endif
    localparam int CNT_W = $clog2(CAP_CNT + 2);
    localparam int MW    = SAMPLE_W + 2;
    localparam int PW    = MW + 5;

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_WAIT, S_LAST} state_t;
    state_t r_state, w_state_next;

    logic [ADDR_W-1:0]   r_start, r_end, r_ptr, r_ram_addr;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_stop;
    logic [SAMPLE_W-1:0] r_sample;
    logic                r_valid, r_done;

    logic                w_start, w_empty, w_issue, w_capture;
    logic [ADDR_W-1:0]   w_next_ptr;
    logic signed [MW-1:0] w_mix;
    logic signed [PW-1:0] w_mix_x, w_vol_x, w_prod, w_res;
    logic [SAMPLE_W-1:0] w_sat;

    assign w_next_ptr = r_ptr + ADDR_W'(1);

    always_ff @(posedge clk_in) begin
        if (!rst_in)
            r_state <= S_IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_empty      = 1'b0;
        w_issue      = 1'b0;
        w_capture    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (play_in && sample_tick_in) begin
                    if (start_addr_in == end_addr_in) begin
                        w_empty = 1'b1;
                    end else begin
                        w_start      = 1'b1;
                        w_state_next = S_FETCH;
                    end
                end
            end
            S_FETCH: begin
                if (r_cnt == CNT_W'(CAP_CNT)) begin
                    w_capture = 1'b1;
                    // A stop request during the fetch wins over the natural end: no done pulse.
                    if (!play_in || r_stop)
                        w_state_next = S_IDLE;
                    else if (w_next_ptr == r_end && !loop_in)
                        w_state_next = S_LAST;
                    else
                        w_state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!play_in) begin
                    w_state_next = S_IDLE;
                end else if (sample_tick_in) begin
                    w_issue      = 1'b1;
                    w_state_next = S_FETCH;
                end
            end
            S_LAST:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

`ifdef LOOP_PLAYER_ECHO_EN
    localparam int ECW = $clog2(ECHO_DELAY + 1);
    logic [SAMPLE_W-1:0]  r_direct;
    logic [ECW-1:0]       r_echo_cnt;
    logic signed [MW-1:0] w_direct_x, w_echo_x;

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_direct   <= '0;
            r_echo_cnt <= '0;
        end else begin
            if (r_state == S_FETCH && r_cnt == CNT_W'(RAM_LATENCY))
                r_direct <= ram_data_in;
            if (w_start)
                r_echo_cnt <= '0;
            else if (w_capture) begin
                if (w_next_ptr == r_end && loop_in)
                    r_echo_cnt <= '0;
                else if (r_echo_cnt < ECW'(ECHO_DELAY))
                    r_echo_cnt <= r_echo_cnt + ECW'(1);
            end
        end
    end

    // Echo read data arrives one cycle after the direct sample, so it is used straight off the bus.
    always_comb begin
        w_direct_x = {{2{r_direct[SAMPLE_W-1]}}, r_direct};
        w_echo_x   = '0;
        if (r_echo_cnt >= ECW'(ECHO_DELAY))
            w_echo_x = {{2{ram_data_in[SAMPLE_W-1]}}, ram_data_in};
        w_mix = w_direct_x + (w_echo_x >>> 1);
    end
`else
    always_comb begin
        w_mix = {{2{ram_data_in[SAMPLE_W-1]}}, ram_data_in};
    end
`endif

    always_comb begin
        w_mix_x = {{(PW-MW){w_mix[MW-1]}}, w_mix};
        w_vol_x = {{(PW-4){1'b0}}, volume_in};
        w_prod  = w_mix_x * w_vol_x;
        w_res   = w_prod >>> 3;
        // In range exactly when all bits from the output sign bit upward agree.
        if (&w_res[PW-1:SAMPLE_W-1] || ~|w_res[PW-1:SAMPLE_W-1])
            w_sat = w_res[SAMPLE_W-1:0];
        else if (w_res[PW-1])
            w_sat = {1'b1, {(SAMPLE_W-1){1'b0}}};
        else
            w_sat = {1'b0, {(SAMPLE_W-1){1'b1}}};
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_start    <= '0;
            r_end      <= '0;
            r_ptr      <= '0;
            r_ram_addr <= '0;
            r_cnt      <= '0;
            r_stop     <= 1'b0;
            r_sample   <= '0;
            r_valid    <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_valid <= w_capture;
            r_done  <= w_empty || (r_state == S_LAST);
            r_cnt   <= (r_state == S_FETCH) ? r_cnt + CNT_W'(1) : '0;
            r_stop  <= (r_state == S_FETCH) && (r_stop || !play_in);
            if (w_start || w_empty) begin
                r_start <= start_addr_in;
                r_end   <= end_addr_in;
                r_ptr   <= start_addr_in;
            end
            if (w_start)
                r_ram_addr <= start_addr_in;
            else if (w_issue)
                r_ram_addr <= r_ptr;
`ifdef LOOP_PLAYER_ECHO_EN
            else if (r_state == S_FETCH && r_cnt == '0)
                r_ram_addr <= r_ptr - ADDR_W'(ECHO_DELAY);
`endif
            if (w_capture) begin
                r_sample <= w_sat;
                r_ptr    <= (w_next_ptr == r_end) ? r_start : w_next_ptr;
            end
        end
    end

    assign ram_addr_out     = r_ram_addr;
    assign sample_out       = r_sample;
    assign sample_valid_out = r_valid;
    assign busy_out         = (r_state != S_IDLE);
    assign done_out         = r_done;

endmodule

// File: tb/tb_loop_player.sv
// Self-checking bench for loop_player: transaction-level model of playback sessions plus gain vectors and reset cases.
module tb_loop_player;
    localparam int L = 2;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic        play_in = 1'b0;
    logic        loop_in = 1'b0;
    logic        sample_tick_in = 1'b0;
    logic [15:0] start_addr_in = '0;
    logic [15:0] end_addr_in = '0;
    logic [3:0]  volume_in = 4'd8;
    logic [15:0] ram_addr_out;
    logic [7:0]  ram_data_in;
    logic [7:0]  sample_out;
    logic        sample_valid_out, busy_out, done_out;

    loop_player dut (
        .clk_in(clk_in), .rst_in(rst_in), .play_in(play_in), .loop_in(loop_in),
        .start_addr_in(start_addr_in), .end_addr_in(end_addr_in),
        .sample_tick_in(sample_tick_in), .volume_in(volume_in),
        .ram_addr_out(ram_addr_out), .ram_data_in(ram_data_in),
        .sample_out(sample_out), .sample_valid_out(sample_valid_out),
        .busy_out(busy_out), .done_out(done_out)
    );

    always #5 clk_in = ~clk_in;

    // Sample RAM with two cycles of read latency.
    logic [7:0] mem [0:65535];
    logic [7:0] rd1;
    always @(posedge clk_in) begin
        rd1         <= mem[ram_addr_out];
        ram_data_in <= rd1;
    end

    typedef struct { int cyc; int val; } ev_t;
    typedef struct { int s; int v; int e; } gv_t;

    ev_t exp_v[$], obs_v[$], exp_a[$];
    int  exp_d[$], obs_d[$];
    int  addr_hist [0:255];
    bit  tick_at [0:255];
    int  busy_seen;
    int  s_start, s_end, s_loop, s_vol, s_poff, s_n;
    int  n_checks = 0;
    int  n_err = 0;
    gv_t gtab [10];

    function automatic int sval(input logic [7:0] b);
        return int'($signed(b));
    endfunction

    // Gain: floor(sample*volume/8), clamped to the signed 8-bit range.
    function automatic int scale(input int s, input int v);
        int p, r;
        p = s * v;
        r = (p >= 0) ? p / 8 : -((-p + 7) / 8);
        if (r > 127) r = 127;
        if (r < -128) r = -128;
        return r;
    endfunction

    task automatic check(input string name, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    task automatic clear_ticks();
        for (int i = 0; i < 256; i++) tick_at[i] = 1'b0;
    endtask

    // Session model: which ticks are accepted, and what each accepted tick produces.
    task automatic build_model();
        int  free = 0;
        bit  idle = 1'b1;
        int  ptr = 0;
        int  nxt;
        exp_v.delete(); exp_a.delete(); exp_d.delete();
        for (int t = 0; t < s_n; t++) begin
            if (!tick_at[t] || t >= s_poff || t < free) continue;
            if (idle) begin
                if (s_start == s_end) begin
                    exp_d.push_back(t + 1);
                    free = t + 1;
                    continue;
                end
                ptr  = s_start;
                idle = 1'b0;
            end
            exp_a.push_back('{t + 1, ptr});
            exp_v.push_back('{t + 2 + L, scale(sval(mem[ptr]), s_vol)});
            nxt = (ptr + 1) % 65536;
            if (s_poff <= t + 1 + L) begin
                idle = 1'b1;
                free = t + 2 + L;
            end else if (nxt == s_end && s_loop == 0) begin
                exp_d.push_back(t + 3 + L);
                idle = 1'b1;
                free = t + 3 + L;
            end else begin
                ptr  = (nxt == s_end) ? s_start : nxt;
                free = t + 2 + L;
            end
        end
    endtask

    task automatic run_session(input string tag);
        int n;
        build_model();
        obs_v.delete(); obs_d.delete();
        busy_seen = 0;
        for (int c = 0; c < s_n; c++) begin
            @(posedge clk_in); #1;
            play_in        = (c < s_poff);
            sample_tick_in = tick_at[c];
            start_addr_in  = 16'(s_start);
            end_addr_in    = 16'(s_end);
            loop_in        = s_loop[0];
            volume_in      = 4'(s_vol);
            @(negedge clk_in);
            addr_hist[c] = int'(ram_addr_out);
            if (sample_valid_out) obs_v.push_back('{c, sval(sample_out)});
            if (done_out) obs_d.push_back(c);
            if (busy_out) busy_seen = 1;
        end
        sample_tick_in = 1'b0;
        play_in        = 1'b0;
        check({tag, " valid_count"}, obs_v.size(), exp_v.size());
        n = (obs_v.size() < exp_v.size()) ? obs_v.size() : exp_v.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s valid%0d_cycle", tag, i), obs_v[i].cyc, exp_v[i].cyc);
            check($sformatf("%s valid%0d_value", tag, i), obs_v[i].val, exp_v[i].val);
        end
        check({tag, " done_count"}, obs_d.size(), exp_d.size());
        n = (obs_d.size() < exp_d.size()) ? obs_d.size() : exp_d.size();
        for (int i = 0; i < n; i++)
            check($sformatf("%s done%0d_cycle", tag, i), obs_d[i], exp_d[i]);
        foreach (exp_a[i])
            check($sformatf("%s addr%0d", tag, i), addr_hist[exp_a[i].cyc], exp_a[i].val);
        check({tag, " busy_at_end"}, int'(busy_out), 0);
    endtask

    initial begin
        int len, c;
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        gtab[0] = '{100, 15, 127};  gtab[1] = '{-100, 15, -128};
        gtab[2] = '{-3, 4, -2};     gtab[3] = '{40, 0, 0};
        gtab[4] = '{16, 8, 16};     gtab[5] = '{-128, 8, -128};
        gtab[6] = '{127, 15, 127};  gtab[7] = '{-1, 1, -1};
        gtab[8] = '{5, 3, 1};       gtab[9] = '{64, 12, 96};

        // Reset state
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        check("reset addr", int'(ram_addr_out), 0);
        check("reset sample", int'(sample_out), 0);
        check("reset valid", int'(sample_valid_out), 0);
        check("reset busy", int'(busy_out), 0);
        check("reset done", int'(done_out), 0);
        @(posedge clk_in); #1 rst_in = 1'b1;

        // One-shot window 0x10..0x14, fifth tick after play is released
        for (int i = 0; i < 4; i++) mem[16 + i] = 8'(16 + i);
        clear_ticks();
        for (int k = 0; k < 5; k++) tick_at[2 + 10 * k] = 1'b1;
        s_start = 16; s_end = 20; s_loop = 0; s_vol = 8; s_n = 60; s_poff = 40;
        run_session("oneshot");
        check("oneshot first_latency", (obs_v.size() > 0) ? obs_v[0].cyc : -1, 6);
        check("oneshot last_value", (obs_v.size() > 3) ? obs_v[3].val : -1, 19);
        check("oneshot done_cycle", (obs_d.size() > 0) ? obs_d[0] : -1, 37);

        // Looped window, ten ticks
        clear_ticks();
        for (int k = 0; k < 10; k++) tick_at[2 + 10 * k] = 1'b1;
        s_loop = 1; s_n = 110; s_poff = 100;
        run_session("loop");
        check("loop addr_wrap", addr_hist[43], 16);

        // Window crossing address 0
        mem[65534] = 8'd7; mem[65535] = 8'hF9; mem[0] = 8'd50; mem[1] = 8'hB0;
        clear_ticks();
        for (int k = 0; k < 4; k++) tick_at[2 + 6 * k] = 1'b1;
        s_start = 65534; s_end = 2; s_loop = 0; s_vol = 11; s_n = 40; s_poff = 35;
        run_session("wrap");
        check("wrap addr0", addr_hist[15], 0);

        // Empty window
        clear_ticks();
        tick_at[3] = 1'b1;
        s_start = 80; s_end = 80; s_loop = 0; s_vol = 8; s_n = 12; s_poff = 10;
        run_session("empty");
        check("empty busy_seen", busy_seen, 0);

        // Play released during the fetch
        clear_ticks();
        tick_at[2] = 1'b1; tick_at[10] = 1'b1;
        s_start = 16; s_end = 20; s_loop = 0; s_n = 20; s_poff = 4;
        run_session("stop");

        // Ticks arriving during a fetch are dropped; a tick in the valid cycle is taken
        clear_ticks();
        for (int k = 2; k <= 6; k++) tick_at[k] = 1'b1;
        s_loop = 1; s_n = 30; s_poff = 20;
        run_session("busytick");

        // Gain and saturation vectors through a one-sample window
        for (int i = 0; i < 10; i++) begin
            mem[256] = 8'(gtab[i].s);
            clear_ticks();
            tick_at[2] = 1'b1;
            s_start = 256; s_end = 257; s_loop = 0; s_vol = gtab[i].v; s_n = 14; s_poff = 12;
            run_session($sformatf("gain%0d", i));
            check($sformatf("gain%0d table", i), (obs_v.size() > 0) ? obs_v[0].val : 999, gtab[i].e);
        end

        // Reset the cycle after an accepted tick
        @(posedge clk_in); #1;
        start_addr_in = 16; end_addr_in = 20; play_in = 1'b1; sample_tick_in = 1'b1;
        @(posedge clk_in); #1;
        sample_tick_in = 1'b0; rst_in = 1'b0;
        @(posedge clk_in); #1;
        rst_in = 1'b1; play_in = 1'b0;
        @(negedge clk_in);
        check("midreset addr", int'(ram_addr_out), 0);
        check("midreset sample", int'(sample_out), 0);
        check("midreset busy", int'(busy_out), 0);
        busy_seen = 0; c = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk_in);
            if (sample_valid_out || done_out) c++;
        end
        check("midreset no_valid_or_done", c, 0);

        // Randomized sessions
        for (int r = 0; r < 25; r++) begin
            s_start = ($urandom_range(0, 1) == 1) ? 65535 - int'($urandom_range(0, 3))
                                                  : int'($urandom_range(0, 65535));
            len     = int'($urandom_range(0, 5));
            s_end   = (s_start + len) % 65536;
            for (int i = 0; i < len; i++) mem[(s_start + i) % 65536] = 8'($urandom_range(0, 255));
            s_loop  = int'($urandom_range(0, 1));
            s_vol   = int'($urandom_range(0, 15));
            s_n     = 80;
            s_poff  = int'($urandom_range(20, 70));
            clear_ticks();
            c = 1 + int'($urandom_range(0, 3));
            while (c < s_n - 12) begin
                tick_at[c] = 1'b1;
                c += int'($urandom_range(1, 8));
            end
            run_session($sformatf("rand%0d", r));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
